ntt_stage_sequencer: RTL and testbench

- Control FSM that drives the butterfly read side and the DataShuffler control inputs for one complete transform.
- Supported passes: a full forward NTT, a full inverse NTT, or a single poly-arithmetic pass.
- Per stage it issues the read-address sweep with `valid`, supplies the shuffler steering fields (`ident_store`, `dest_rom_gap`, `swap_store`, `is_poly_arith`), then waits for the pipeline to drain before starting the next stage.
- Sits between the top-level command interface and the butterfly/DataShuffler/RAM datapath.

---
 rtl/ntt_ctrl_pkg.sv | 40 ++++
 rtl/stage_addr_gen.sv | 40 ++++
 rtl/ntt_stage_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ntt_ctrl_pkg
// Shared types and helpers for the NTT control path.
//   mode_t      : transform kind latched on an accepted command
//   seq_state_t : stage sequencer FSM states
//   decode_mode : maps the 2-bit command mode onto mode_t (3 folds onto POLY)
//   stage_gap   : cross-lane gap for butterfly distance index t
// ---------------------------------------------------------------------------
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_POLY = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_NTT;
            2'd1:    return MODE_INTT;
            default: return MODE_POLY;
        endcase
    endfunction

    // PE is a power of two, so PE >> t is >= 2 exactly when t < log2(PE);
    // beyond that the partner is in the same lane set and the gap is 1.
    function automatic int stage_gap(input int t, input int pe);
        int g;
        g = pe >> t;
        return (g < 1) ? 1 : g;
    endfunction

endpackage

// File: rtl/stage_addr_gen.sv
// ---------------------------------------------------------------------------
// stage_addr_gen
// Butterfly read-address counter for one stage sweep.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart the sweep at address 0 (has priority over inc_i)
//   inc_i      : advance to the next address; saturates at DEPTH-1
//   addr_o     : current address (registered)
//   last_o     : addr_o is the final address of the sweep
// ---------------------------------------------------------------------------
module stage_addr_gen #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              last;

    assign last = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (clr_i) begin
            addr_q <= '0;
        end else if (inc_i && !last) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = last;

endmodule

// File: rtl/ntt_stage_sequencer.sv
// ---------------------------------------------------------------------------
// ntt_stage_sequencer
// Sequences one full NTT / INTT (LOGN stages) or a single poly-arithmetic
// pass: per stage it sweeps the butterfly read address with valid, drives the
// DataShuffler steering fields, then idles DRAIN_CYC cycles so the pipeline
// empties before the next stage.
//   clk, rst_n    : clock, async active-low reset
//   start, mode   : command pulse and transform kind (sampled in IDLE only)
//   stall         : hold address issue while high
//   busy, done    : operation in flight / one-cycle completion pulse
//   stage         : current stage index s
//   bf_rd_addr    : butterfly read / writeback address, qualified by valid
//   ident_store, dest_rom_gap, swap_store, is_poly_arith : shuffler steering
//
// All outputs are registered; a stage's first address is issued on the same
// edge that enters RUN, so valid appears the cycle after start is sampled.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | issuing addresses of stage s (holds while stall is high)
//   DRAIN | last address issued, counting down the pipeline latency
//   DONE  | transform finished; done pulses as this state exits
// ---------------------------------------------------------------------------
module ntt_stage_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter  int LOGN      = 8,
    parameter  int PE        = 2,
    parameter  int DRAIN_CYC = 8,
    localparam int N         = 1 << LOGN,
    localparam int DEPTH     = N / 2 / PE,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LOGPE     = $clog2(PE),
    localparam int STG_W     = (LOGN > 1) ? $clog2(LOGN) : 1,
    localparam int GAP_W     = LOGPE + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [STG_W-1:0]  stage,
    output logic [ADDR_W-1:0] bf_rd_addr,
    output logic              valid,
    output logic              ident_store,
    output logic [GAP_W-1:0]  dest_rom_gap,
    output logic              swap_store,
    output logic              is_poly_arith
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    seq_state_t        state_q;
    mode_t             mode_q;
    logic [STG_W-1:0]  stage_q;
    logic [DRN_W-1:0]  drain_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              ident_q;
    logic [GAP_W-1:0]  gap_q;
    logic              swap_q;
    logic              poly_q;

    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              addr_clr;
    logic              addr_inc;

    logic              drain_end;
    logic              last_stage;

    mode_t             mode_sel;
    mode_t             mode_nxt;
    logic [STG_W-1:0]  stage_nxt;
    int                t_nxt;
    logic              poly_nxt;
    logic              ident_nxt;
    logic [GAP_W-1:0]  gap_nxt;

    // Steering for the stage about to start: stage 0 of the incoming command
    // when leaving IDLE, otherwise stage s+1 of the latched command.
    always_comb begin
        mode_sel  = decode_mode(mode);
        mode_nxt  = (state_q == IDLE) ? mode_sel : mode_q;
        stage_nxt = (state_q == IDLE) ? '0 : stage_q + STG_W'(1);
        t_nxt     = (mode_nxt == MODE_INTT) ? (LOGN - 1 - int'(stage_nxt))
                                            : int'(stage_nxt);
        poly_nxt  = (mode_nxt == MODE_POLY);
        ident_nxt = poly_nxt || (t_nxt == LOGN - 1);
        gap_nxt   = GAP_W'(stage_gap(t_nxt, PE));
    end

    assign drain_end  = (drain_q <= DRN_W'(1));
    assign last_stage = poly_q || (stage_q == STG_W'(LOGN - 1));

    assign addr_clr = ((state_q == IDLE) && start) ||
                      ((state_q == DRAIN) && drain_end && !last_stage);
    assign addr_inc = (state_q == RUN) && !addr_last && !stall;

    stage_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (addr_clr),
        .inc_i  (addr_inc),
        .addr_o (addr),
        .last_o (addr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_NTT;
            stage_q <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ident_q <= 1'b0;
            gap_q   <= '0;
            swap_q  <= 1'b0;
            poly_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        mode_q  <= mode_sel;
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        ident_q <= ident_nxt;
                        gap_q   <= gap_nxt;
                        poly_q  <= poly_nxt;
                        swap_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // addr_last here means the final address was issued on
                    // the previous edge, so the stall input no longer matters.
                    if (addr_last) begin
                        state_q <= DRAIN;
                        valid_q <= 1'b0;
                        drain_q <= DRN_W'(DRAIN_CYC);
                    end else if (stall) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        // LSB of the address being issued (addr + 1)
                        swap_q  <= poly_q & ~addr[0];
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        if (last_stage) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                            stage_q <= stage_nxt;
                            valid_q <= 1'b1;
                            ident_q <= ident_nxt;
                            gap_q   <= gap_nxt;
                            poly_q  <= poly_nxt;
                            swap_q  <= 1'b0;
                        end
                    end else begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign stage         = stage_q;
    assign bf_rd_addr    = addr;
    assign valid         = valid_q;
    assign ident_store   = ident_q;
    assign dest_rom_gap  = gap_q;
    assign swap_store    = swap_q;
    assign is_poly_arith = poly_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
module tb_ntt_stage_sequencer;

    localparam int LOGN      = 4;
    localparam int PE        = 2;
    localparam int DRAIN_CYC = 8;
    localparam int DEPTH     = (1 << LOGN) / 2 / PE;
    localparam int LOGPE     = 1;
    localparam int STAGE_LEN = DEPTH + DRAIN_CYC;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] mode  = 2'd0;

    logic       busy, done, valid, ident_store, swap_store, is_poly_arith;
    logic [1:0] stage;
    logic [1:0] bf_rd_addr;
    logic [1:0] dest_rom_gap;

    logic       p1_busy, p1_done, p1_valid, p1_ident, p1_swap, p1_poly;
    logic [1:0] p1_stage;
    logic [2:0] p1_addr;
    logic [0:0] p1_gap;

    ntt_stage_sequencer #(.LOGN(LOGN), .PE(PE), .DRAIN_CYC(DRAIN_CYC)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stall(stall),
        .busy(busy), .done(done), .stage(stage), .bf_rd_addr(bf_rd_addr),
        .valid(valid), .ident_store(ident_store), .dest_rom_gap(dest_rom_gap),
        .swap_store(swap_store), .is_poly_arith(is_poly_arith)
    );

    // Single-lane build sharing the same command inputs.
    ntt_stage_sequencer #(.LOGN(LOGN), .PE(1), .DRAIN_CYC(DRAIN_CYC)) u_dut_pe1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stall(stall),
        .busy(p1_busy), .done(p1_done), .stage(p1_stage), .bf_rd_addr(p1_addr),
        .valid(p1_valid), .ident_store(p1_ident), .dest_rom_gap(p1_gap),
        .swap_store(p1_swap), .is_poly_arith(p1_poly)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int stage;
        int addr;
        int ident;
        int gap;
        int swap;
        int poly;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    done_seen = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: every stage sweeps addresses 0..DEPTH-1 in order; steering is
    // a pure function of mode and stage; completion time follows from the
    // stage length plus stalled cycles (extra < 0 means timing not checked).
    task automatic model_op(input int m, input int start_cyc, input int extra);
        bit is_poly;
        bit intt;
        int nst;
        is_poly = (m >= 2);
        intt    = (m == 1);
        nst     = is_poly ? 1 : LOGN;
        for (int s = 0; s < nst; s++) begin
            int t;
            t = intt ? (LOGN - 1 - s) : s;
            for (int a = 0; a < DEPTH; a++) begin
                beat_t b;
                b.stage = s;
                b.addr  = a;
                b.poly  = is_poly;
                b.ident = (is_poly || t == LOGN - 1);
                b.gap   = (t < LOGPE) ? (PE >> t) : 1;
                b.swap  = is_poly ? (a % 2) : 0;
                exp_q.push_back(b);
            end
        end
        done_q.push_back((extra < 0) ? -1 : start_cyc + 1 + nst * STAGE_LEN + extra);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns the cycle stamp of the sampling edge.
    task automatic issue_start(input int m, input int extra, output int s_cyc);
        mode  = m[1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        s_cyc = cyc;
        model_op(m, s_cyc, extra);
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        int n;
        base = done_seen;
        n    = 0;
        while (done_seen == base && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done_seen - base, 1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},  busy,          0);
        check({pfx, "_done"},  done,          0);
        check({pfx, "_valid"}, valid,         0);
        check({pfx, "_stage"}, stage,         0);
        check({pfx, "_addr"},  bf_rd_addr,    0);
        check({pfx, "_ident"}, ident_store,   0);
        check({pfx, "_gap"},   dest_rom_gap,  0);
        check({pfx, "_swap"},  swap_store,    0);
        check({pfx, "_poly"},  is_poly_arith, 0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t b;
        int    e;
        if (rst_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_addr", bf_rd_addr, -1);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_stage", stage,         b.stage);
                    check("beat_addr",  bf_rd_addr,    b.addr);
                    check("beat_ident", ident_store,   b.ident);
                    check("beat_gap",   dest_rom_gap,  b.gap);
                    check("beat_swap",  swap_store,    b.swap);
                    check("beat_poly",  is_poly_arith, b.poly);
                    check("beat_busy",  busy,          1);
                end
            end
            if (done) begin
                done_seen++;
                check("done_busy_low", busy, 0);
                check("done_beats_left", exp_q.size(), 0);
                if (done_q.size() == 0) begin
                    check("unexpected_done_cycle", cyc, -1);
                end else begin
                    e = done_q.pop_front();
                    if (e >= 0) check("done_cycle", cyc, e);
                end
            end
            if (p1_valid) check("pe1_gap", p1_gap, 1);
        end
    end

    initial begin
        int s0;
        // reset state
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // NTT: first-valid timing, drain gap, stage turnover
        issue_start(0, 0, s0);
        check("ntt_first_valid", valid, 1);
        check("ntt_first_addr", bf_rd_addr, 0);
        check("ntt_busy", busy, 1);
        repeat (DEPTH) tick();
        check("ntt_drain_valid_low", valid, 0);
        repeat (DRAIN_CYC) tick();
        check("ntt_s1_valid", valid, 1);
        check("ntt_s1_stage", stage, 1);
        wait_done("ntt", 200);

        // INTT with start pulsed while busy and in the DONE cycle
        issue_start(1, 0, s0);
        repeat (10) tick();
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s0 + 1 + LOGN * STAGE_LEN - 1) tick();
        check("intt_busy_in_done", busy, 1);
        start = 1'b1;
        mode  = 2'd2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("start_in_done_busy", busy, 0);
        check("start_in_done_valid", valid, 0);
        check("intt_done_count", done_seen, 2);

        // POLY and reserved mode 3
        issue_start(2, 0, s0);
        wait_done("poly", 100);
        issue_start(3, 0, s0);
        wait_done("mode3", 100);

        // stall 3 cycles at stage 1, address 2
        issue_start(0, 3, s0);
        while (cyc < s0 + STAGE_LEN + 2) tick();
        check("stall_pre_addr", bf_rd_addr, 2);
        check("stall_pre_stage", stage, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_valid", valid, 0);
            check("stall_hold_addr", bf_rd_addr, 2);
        end
        stall = 1'b0;
        tick();
        check("stall_release_addr", bf_rd_addr, 3);
        check("stall_release_valid", valid, 1);
        wait_done("stall", 200);

        // reset in DRAIN of stage 2, then a fresh full transform
        issue_start(0, 0, s0);
        while (cyc < s0 + 2 * STAGE_LEN + DEPTH + 2) tick();
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        exp_q.delete();
        done_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("abort_no_done", done_seen, 5);
        issue_start(0, 0, s0);
        check("post_abort_stage", stage, 0);
        wait_done("post_abort", 200);

        // randomized commands with random stalls
        for (int k = 0; k < 6; k++) begin
            int m;
            int base;
            int n;
            repeat ($urandom_range(0, 3)) tick();
            m = $urandom_range(0, 3);
            issue_start(m, -1, s0);
            base = done_seen;
            n    = 0;
            while (done_seen == base && n < 1000) begin
                stall = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            stall = 1'b0;
            check("rand_done_seen", done_seen - base, 1);
        end

        repeat (80) tick();
        check("final_beats_left", exp_q.size(), 0);
        check("final_dones_left", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
